fp_seq_gen_mm: RTL

- Next-generation IEEE-754 single-precision arithmetic sequence generator: emits a1, a1+d, a1+2d, … over a valid/ready stream.
- Adds output backpressure, a parametrised term counter, and three modes: one-shot, repeat and ping-pong.
- Sits between the register/config block and the sample stream consumer (DAC formatter / FIFO) in the signal-generator datapath.

---
 rtl/fp_seq_pkg.sv | 35 +++
 rtl/fp32_add.sv | 93 +++++++++
 rtl/fp_seq_gen_mm.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fp_seq_pkg.sv
// Shared types and binary32 constants for the arithmetic sequence generator.
package fp_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_ONESHOT  = 2'd0,
    SEQ_REPEAT   = 2'd1,
    SEQ_PINGPONG = 2'd2
  } seq_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam int          EXP_W      = 8;
  localparam int          MAN_W      = 23;
  localparam int          BIAS       = 127;

  // The reserved encoding behaves as one-shot.
  function automatic seq_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return SEQ_REPEAT;
      2'd2:    return SEQ_PINGPONG;
      default: return SEQ_ONESHOT;
    endcase
  endfunction

  function automatic logic fp_is_special(input logic [31:0] x);
    return &x[MAN_W+EXP_W-1:MAN_W];
  endfunction

endpackage

// File: rtl/fp32_add.sv
// Combinational binary32 adder: align, add/sub, normalise, round-to-nearest-even,
// with subnormal inputs and results flushed to +0.
module fp32_add
  import fp_seq_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  localparam int SIG_W  = MAN_W + 1;         // significand with hidden bit
  localparam int EXT_W  = SIG_W + 3;         // plus guard, round, sticky
  localparam int WIDE_W = SIG_W + EXT_W - 1; // alignment window
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

  logic               a_sign, b_sign, l_sign;
  logic [EXP_W-1:0]   a_exp, b_exp, l_exp, s_exp, diff;
  logic [MAN_W-1:0]   a_man, b_man;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, eff_sub;
  logic [SIG_W-1:0]   l_sig, s_sig;
  logic [WIDE_W-1:0]  wide_sh;
  logic [EXT_W-1:0]   l_ext, s_ext, norm;
  logic [EXT_W:0]     raw;
  logic [4:0]         lz;
  logic signed [EXP_W+1:0] exp_n, exp_r;
  logic               round_up;
  logic [SIG_W:0]     rounded;
  logic [MAN_W-1:0]   man_r;

  assign {a_sign, a_exp, a_man} = a_i;
  assign {b_sign, b_exp, b_man} = b_i;
  assign a_zero  = (a_exp == '0);
  assign b_zero  = (b_exp == '0);
  assign a_inf   = (a_exp == EXP_MAX) && (a_man == '0);
  assign b_inf   = (b_exp == EXP_MAX) && (b_man == '0);
  assign a_nan   = (a_exp == EXP_MAX) && (a_man != '0);
  assign b_nan   = (b_exp == EXP_MAX) && (b_man != '0);
  assign eff_sub = a_sign ^ b_sign;

  // NOTE: every variable written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    l_sign  = a_sign;
    l_exp   = a_exp;
    s_exp   = b_exp;
    l_sig   = {1'b1, a_man};
    s_sig   = {1'b1, b_man};
    if ({b_exp, b_man} > {a_exp, a_man}) begin
      l_sign = b_sign;
      l_exp  = b_exp;
      s_exp  = a_exp;
      l_sig  = {1'b1, b_man};
      s_sig  = {1'b1, a_man};
    end
    diff    = l_exp - s_exp;
    l_ext   = {l_sig, 3'b000};
    wide_sh = {s_sig, {(EXT_W-1){1'b0}}} >> diff;
    s_ext   = {wide_sh[WIDE_W-1 -: EXT_W-1], |wide_sh[WIDE_W-EXT_W:0]};
    if (diff >= EXP_W'(WIDE_W)) s_ext = EXT_W'(1);

    raw = eff_sub ? ({1'b0, l_ext} - {1'b0, s_ext}) : ({1'b0, l_ext} + {1'b0, s_ext});

    lz = 5'(EXT_W);
    for (int i = 0; i < EXT_W; i++) begin
      if (raw[i]) lz = 5'(EXT_W - 1 - i);
    end

    if (raw[EXT_W]) begin
      norm  = {raw[EXT_W:2], raw[1] | raw[0]};
      exp_n = $signed({2'b00, l_exp}) + 10'sd1;
    end else begin
      norm  = raw[EXT_W-1:0] << lz;
      exp_n = $signed({2'b00, l_exp}) - $signed({5'b00000, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, round_up};
    exp_r    = rounded[SIG_W] ? exp_n + 10'sd1 : exp_n;
    man_r    = rounded[SIG_W] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];

    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) sum_o = FP_QNAN;
    else if (a_inf)                                    sum_o = a_i;
    else if (b_inf)                                    sum_o = b_i;
    else if (a_zero && b_zero)                         sum_o = '0;
    else if (a_zero)                                   sum_o = b_i;
    else if (b_zero)                                   sum_o = a_i;
    else if (raw == '0)                                sum_o = '0;
    else if (exp_r >= $signed({2'b00, EXP_MAX}))       sum_o = {l_sign, FP_POS_INF[30:0]};
    else if (exp_r <= 10'sd0)                          sum_o = '0;
    else                                               sum_o = {l_sign, exp_r[EXP_W-1:0], man_r};
  end

endmodule

// File: rtl/fp_seq_gen_mm.sv
// Binary32 arithmetic sequence generator with valid/ready output and one-shot,
// repeat and ping-pong modes. Define FP_SEQ_STATUS_EN for term_idx/ovf_sticky.
module fp_seq_gen_mm
  import fp_seq_pkg::*;
#(
  parameter int COUNT_W = 32,
  parameter int FTZ     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [31:0]        a1,
  input  logic [31:0]        d,
  input  logic [COUNT_W-1:0] n,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        term,
`ifdef FP_SEQ_STATUS_EN
  output logic [COUNT_W-1:0] term_idx,
  output logic               ovf_sticky,
`endif
  output logic               done,
  output logic               busy
);

  if (FTZ != 1) begin : g_ftz_unsupported
    $error("fp_seq_gen_mm: only FTZ=1 is supported");
  end

  state_e             state_q, state_d;
  logic [31:0]        term_q, term_d, cfg_a1_q, cfg_a1_d, cfg_d_q, cfg_d_d;
  logic [COUNT_W-1:0] idx_q, idx_d, cfg_n_q, cfg_n_d;
  seq_mode_e          cfg_mode_q, cfg_mode_d;
  logic               dir_down_q, dir_down_d;
  logic               fire, start_ok, last, step_down;
  logic [31:0]        addend, sum;

  assign fire     = (state_q == ST_RUN) && out_ready;
  assign start_ok = start && (state_q != ST_RUN);
  assign last     = (idx_q == cfg_n_q - COUNT_W'(1));
  // Ping-pong turns around at either end, so each endpoint is emitted once per pass.
  assign step_down = (cfg_mode_q == SEQ_PINGPONG) && (dir_down_q ? (idx_q != '0) : last);
  assign addend    = step_down ? {~cfg_d_q[31], cfg_d_q[30:0]} : cfg_d_q;

  fp32_add u_add (
    .a_i  (term_q),
    .b_i  (addend),
    .sum_o(sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = (n == '0) ? ST_DONE : ST_RUN;
        ST_RUN:           if (fire && last && cfg_mode_q == SEQ_ONESHOT) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == ST_RUN);
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    term      = term_q;
  end

  always_comb begin
    term_d     = term_q;
    idx_d      = idx_q;
    dir_down_d = dir_down_q;
    cfg_a1_d   = cfg_a1_q;
    cfg_d_d    = cfg_d_q;
    cfg_n_d    = cfg_n_q;
    cfg_mode_d = cfg_mode_q;
    if (!abort) begin
      if (start_ok) begin
        cfg_a1_d   = a1;
        cfg_d_d    = d;
        cfg_n_d    = n;
        cfg_mode_d = decode_mode(mode);
        term_d     = a1;
        idx_d      = '0;
        dir_down_d = 1'b0;
      end else if (fire) begin
        case (cfg_mode_q)
          SEQ_REPEAT: begin
            term_d = last ? cfg_a1_q : sum;
            idx_d  = last ? '0 : idx_q + COUNT_W'(1);
          end
          SEQ_PINGPONG: begin
            if (cfg_n_q != COUNT_W'(1)) begin
              term_d     = sum;
              dir_down_d = step_down;
              idx_d      = step_down ? idx_q - COUNT_W'(1) : idx_q + COUNT_W'(1);
            end
          end
          default: begin
            if (!last) begin
              term_d = sum;
              idx_d  = idx_q + COUNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_q     <= '0;
      idx_q      <= '0;
      dir_down_q <= 1'b0;
      cfg_a1_q   <= '0;
      cfg_d_q    <= '0;
      cfg_n_q    <= '0;
      cfg_mode_q <= SEQ_ONESHOT;
    end else begin
      term_q     <= term_d;
      idx_q      <= idx_d;
      dir_down_q <= dir_down_d;
      cfg_a1_q   <= cfg_a1_d;
      cfg_d_q    <= cfg_d_d;
      cfg_n_q    <= cfg_n_d;
      cfg_mode_q <= cfg_mode_d;
    end
  end

`ifdef FP_SEQ_STATUS_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (!abort && start_ok)  ovf_d = fp_is_special(a1);
    else if (!abort && fire) ovf_d = ovf_q | fp_is_special(term_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign term_idx   = idx_q;
  assign ovf_sticky = ovf_q;
`endif

endmodule
